// File: rtl/rec_rx_pkg.sv
// Shared types and constants for the REC serial-lane receive deframer.
package rec_rx_pkg;

    localparam int SLOT_LEN = 34;
    localparam int HDR_WIN  = 16;
    localparam int HDR_BITS = 7;
    localparam int CHAN_NUM = 32;
    localparam int CNT_W    = 5;
    localparam int IDX_W    = $clog2(CHAN_NUM);

    typedef enum logic [2:0] {
        IDLE,
        HDR_WAIT,
        HDR_SHIFT,
        GAP,
        DATA_SHIFT
    } state_t;

    // Header field order as it arrives on the lane, MSB first.
    typedef struct packed {
        logic             imp;
        logic [IDX_W-1:0] idx;
        logic             disch;
    } hdr_t;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return IDX_W'((int'(idx) + 1) % CHAN_NUM);
    endfunction

endpackage

// File: rtl/rec_rx_shift.sv
// Serial-in/parallel-out shift register, MSB first, with synchronous clear
// (priority over enable); nxt_o is the value the next enabled shift will load.
module rec_rx_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] nxt_o
);

    assign nxt_o = WIDTH'({q_o, bit_i});

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            q_o <= '0;
        end else if (clr_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= nxt_o;
        end
    end

endmodule

// File: rtl/rec_rx_deframer.sv
// Deframes one REC serial lane (header + ADC word per 34-cycle slot); one
// instance per ADC lane. Define REC_RX_SEQ_CHECK_EN for the channel-index continuity check.
module rec_rx_deframer
    import rec_rx_pkg::*;
#(
    parameter int ADC_BITS = 16,
    parameter int ADC_LAT  = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic                sample_i,
    input  logic                rec_data_i,
    output logic                word_valid_o,
    output logic [IDX_W-1:0]    chan_idx_o,
    output logic                imp_o,
    output logic                disch_o,
    output logic [ADC_BITS-1:0] sample_o,
    output logic                hdr_err_o,
    output logic                len_err_o,
    output logic                seq_err_o
);

    localparam int DATA_WIN = SLOT_LEN - HDR_WIN;

    if (ADC_BITS < 1 || ADC_LAT < 0 || ADC_BITS + ADC_LAT > DATA_WIN) begin : g_bad_cfg
        $error("rec_rx_deframer: ADC_BITS/ADC_LAT outside legal range");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sample_q;
    logic               rise, fall_or_low;

    logic               hdr_clr, hdr_en;
    logic               dat_clr, dat_en;
    logic               valid_d, hdr_err_d, len_err_d;

    logic [HDR_BITS-1:0] hdr_q;
    logic [HDR_BITS-1:0] hdr_nxt_unused;
    logic [ADC_BITS-1:0] dat_q_unused;
    logic [ADC_BITS-1:0] dat_nxt;
    hdr_t                hdr;

    assign rise        = sample_i & ~sample_q;
    assign fall_or_low = ~sample_i;
    assign hdr         = hdr_t'(hdr_q);

    rec_rx_shift #(.WIDTH(HDR_BITS)) u_hdr_shift (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (hdr_clr),
        .en_i    (hdr_en),
        .bit_i   (rec_data_i),
        .q_o     (hdr_q),
        .nxt_o   (hdr_nxt_unused)
    );

    rec_rx_shift #(.WIDTH(ADC_BITS)) u_dat_shift (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (dat_clr),
        .en_i    (dat_en),
        .bit_i   (rec_data_i),
        .q_o     (dat_q_unused),
        .nxt_o   (dat_nxt)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_clr   = 1'b0;
        hdr_en    = 1'b0;
        dat_clr   = 1'b0;
        dat_en    = 1'b0;
        valid_d   = 1'b0;
        hdr_err_d = 1'b0;
        len_err_d = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The rise cycle is already header bit 0, so it may carry the start bit.
                    if (rise) begin
                        hdr_clr = 1'b1;
                        dat_clr = 1'b1;
                        state_d = rec_data_i ? HDR_SHIFT : HDR_WAIT;
                        cnt_d   = CNT_W'(HDR_BITS);
                    end
                end
                HDR_WAIT: begin
                    if (fall_or_low) begin
                        hdr_err_d = 1'b1;
                        state_d   = IDLE;
                    end else if (rec_data_i) begin
                        state_d = HDR_SHIFT;
                        cnt_d   = CNT_W'(HDR_BITS);
                    end
                end
                HDR_SHIFT: begin
                    if (fall_or_low) begin
                        hdr_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        hdr_en = 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = GAP;
                            cnt_d   = CNT_W'(ADC_LAT);
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (rise) begin
                        len_err_d = 1'b1;
                        hdr_clr   = 1'b1;
                        dat_clr   = 1'b1;
                        state_d   = rec_data_i ? HDR_SHIFT : HDR_WAIT;
                        cnt_d     = CNT_W'(HDR_BITS);
                    end else if (fall_or_low) begin
                        // cnt_q counts down the ADC latency from the falling-edge cycle.
                        if (cnt_q == '0) begin
                            dat_en = 1'b1;
                            if (ADC_BITS == 1) begin
                                valid_d = 1'b1;
                                state_d = IDLE;
                            end else begin
                                state_d = DATA_SHIFT;
                                cnt_d   = CNT_W'(ADC_BITS - 1);
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                DATA_SHIFT: begin
                    if (rise) begin
                        len_err_d = 1'b1;
                        hdr_clr   = 1'b1;
                        dat_clr   = 1'b1;
                        state_d   = rec_data_i ? HDR_SHIFT : HDR_WAIT;
                        cnt_d     = CNT_W'(HDR_BITS);
                    end else begin
                        dat_en = 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // sample_q resets high so a window already in progress at reset release
    // is not mistaken for a slot start.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sample_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            word_valid_o <= 1'b0;
            hdr_err_o    <= 1'b0;
            len_err_o    <= 1'b0;
            chan_idx_o   <= '0;
            imp_o        <= 1'b0;
            disch_o      <= 1'b0;
            sample_o     <= '0;
        end else begin
            word_valid_o <= valid_d;
            hdr_err_o    <= hdr_err_d;
            len_err_o    <= len_err_d;
            if (valid_d) begin
                chan_idx_o <= hdr.idx;
                imp_o      <= hdr.imp;
                disch_o    <= hdr.disch;
                sample_o   <= dat_nxt;
            end
        end
    end

`ifdef REC_RX_SEQ_CHECK_EN
    logic [IDX_W-1:0] exp_idx_q;
    logic             exp_vld_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            exp_idx_q <= '0;
            exp_vld_q <= 1'b0;
            seq_err_o <= 1'b0;
        end else begin
            seq_err_o <= valid_d && exp_vld_q && (hdr.idx != exp_idx_q);
            if (!en_i) begin
                exp_vld_q <= 1'b0;
            end else if (valid_d) begin
                exp_idx_q <= next_idx(hdr.idx);
                exp_vld_q <= 1'b1;
            end
        end
    end
`else
    assign seq_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rec_rx_deframer.sv
// Directed bench for rec_rx_deframer (ADC_BITS=16, ADC_LAT=1).
module tb_rec_rx_deframer;

    localparam int ADC_BITS = 16;
    localparam int ADC_LAT  = 1;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                en_i;
    logic                sample_i;
    logic                rec_data_i;
    logic                word_valid_o;
    logic [4:0]          chan_idx_o;
    logic                imp_o;
    logic                disch_o;
    logic [ADC_BITS-1:0] sample_o;
    logic                hdr_err_o;
    logic                len_err_o;
    logic                seq_err_o;

    rec_rx_deframer #(.ADC_BITS(ADC_BITS), .ADC_LAT(ADC_LAT)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .en_i         (en_i),
        .sample_i     (sample_i),
        .rec_data_i   (rec_data_i),
        .word_valid_o (word_valid_o),
        .chan_idx_o   (chan_idx_o),
        .imp_o        (imp_o),
        .disch_o      (disch_o),
        .sample_o     (sample_o),
        .hdr_err_o    (hdr_err_o),
        .len_err_o    (len_err_o),
        .seq_err_o    (seq_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int n_valid, n_hdr, n_len, n_seq;
    int valid_k, hdr_k, len_k;
    int n_excl = 0;
    logic [4:0] seq_idx;
    int exp_seq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_valid = 0; n_hdr = 0; n_len = 0; n_seq = 0;
        valid_k = -1; hdr_k = -1; len_k = -1;
        seq_idx = '1;
    endtask

    // Advance one clock and record pulses registered from this cycle's inputs.
    task automatic step(input int k);
        @(posedge clk_i);
        #1;
        if (word_valid_o) begin n_valid++; valid_k = k; end
        if (hdr_err_o)    begin n_hdr++;   hdr_k   = k; end
        if (len_err_o)    begin n_len++;   len_k   = k; end
        if (seq_err_o)    begin n_seq++;   seq_idx = chan_idx_o; end
        if ((int'(word_valid_o) + int'(hdr_err_o) + int'(len_err_o) > 1) ||
            (seq_err_o && !word_valid_o))
            n_excl++;
    endtask

    function automatic logic [6:0] mk_hdr(input logic imp, input logic [4:0] idx, input logic disch);
        return {imp, idx, disch};
    endfunction

    // start < 0: no start bit in the window; len < 34 truncates the slot.
    task automatic send_slot(input logic [6:0] hdr, input logic [15:0] adc, input int start,
                             input int len, input int rst_at, input int en_low_at);
        for (int k = 0; k < len; k++) begin
            sample_i   = (k < 16);
            rec_data_i = 1'b0;
            if (k < 16 && start >= 0) begin
                if (k == start)
                    rec_data_i = 1'b1;
                else if (k > start && k <= start + 7)
                    rec_data_i = hdr[6 - (k - start - 1)];
            end
            if (k >= 16 + ADC_LAT && k < 16 + ADC_LAT + ADC_BITS)
                rec_data_i = adc[ADC_BITS - 1 - (k - 16 - ADC_LAT)];
            reset_i = (k == rst_at);
            en_i    = (k != en_low_at);
            step(k);
        end
        reset_i = 1'b0;
        en_i    = 1'b1;
    endtask

`ifdef REC_RX_SEQ_CHECK_EN
    localparam int SEQ_ON = 1;
`else
    localparam int SEQ_ON = 0;
`endif

    initial begin
        reset_i = 1'b1; en_i = 1'b1; sample_i = 1'b0; rec_data_i = 1'b0;
        clear_mon();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", 32'(word_valid_o), 0);
        check("rst_chan",  32'(chan_idx_o),   0);
        check("rst_imp",   32'(imp_o),        0);
        check("rst_disch", 32'(disch_o),      0);
        check("rst_sample",32'(sample_o),     0);
        check("rst_hdr",   32'(hdr_err_o),    0);
        check("rst_len",   32'(len_err_o),    0);
        check("rst_seq",   32'(seq_err_o),    0);
        reset_i = 1'b0;
        step(0); step(0);

        // Basic slot: imp=1 idx=5 disch=0 ADC=0xA5C3, start bit at window position 0.
        clear_mon();
        send_slot(mk_hdr(1'b1, 5'd5, 1'b0), 16'hA5C3, 0, 34, -1, -1);
        check("s1_nvalid",  n_valid, 1);
        check("s1_valid_k", valid_k, 32);
        check("s1_chan",    32'(chan_idx_o), 5);
        check("s1_imp",     32'(imp_o), 1);
        check("s1_disch",   32'(disch_o), 0);
        check("s1_sample",  32'(sample_o), 32'hA5C3);
        check("s1_errs",    n_hdr + n_len + n_seq, 0);

        // Latest possible start bit (position 8).
        clear_mon();
        send_slot(mk_hdr(1'b0, 5'd6, 1'b1), 16'h0001, 8, 34, -1, -1);
        check("s2_nvalid", n_valid, 1);
        check("s2_chan",   32'(chan_idx_o), 6);
        check("s2_imp",    32'(imp_o), 0);
        check("s2_disch",  32'(disch_o), 1);
        check("s2_sample", 32'(sample_o), 32'h0001);
        check("s2_errs",   n_hdr + n_len + n_seq, 0);

        // Index 0..31 then 0 after an en_i gap: 33 words, wrap is not a sequence error.
        en_i = 1'b0; step(0); en_i = 1'b1; step(0);
        clear_mon();
        for (int i = 0; i <= 32; i++)
            send_slot(mk_hdr(1'(i), 5'(i % 32), 1'b0), 16'(i * 16'h0101), 3, 34, -1, -1);
        check("wrap_nvalid", n_valid, 33);
        check("wrap_nseq",   n_seq, 0);
        check("wrap_chan",   32'(chan_idx_o), 0);
        check("wrap_sample", 32'(sample_o), 32'h2020);
        check("wrap_errs",   n_hdr + n_len, 0);

        // Skip index 7: only the idx-8 word may flag a sequence error.
        clear_mon();
        for (int i = 1; i <= 9; i++)
            if (i != 7)
                send_slot(mk_hdr(1'b0, 5'(i), 1'b0), 16'hC000 | 16'(i), 0, 34, -1, -1);
        exp_seq = SEQ_ON;
        check("skip_nvalid", n_valid, 8);
        check("skip_nseq",   n_seq, exp_seq);
        if (SEQ_ON == 1)
            check("skip_seq_idx", 32'(seq_idx), 8);
        check("skip_chan",   32'(chan_idx_o), 9);

        // No start bit in the window.
        clear_mon();
        send_slot(7'h00, 16'hFFFF, -1, 34, -1, -1);
        check("hdr_nhdr",   n_hdr, 1);
        check("hdr_k",      hdr_k, 16);
        check("hdr_nvalid", n_valid, 0);
        check("hdr_chan",   32'(chan_idx_o), 9);
        check("hdr_sample", 32'(sample_o), 32'hC009);

        // Truncated after 6 ADC bits, then a full slot with the same index.
        clear_mon();
        send_slot(mk_hdr(1'b0, 5'd10, 1'b0), 16'hFFFF, 0, 16 + ADC_LAT + 6, -1, -1);
        send_slot(mk_hdr(1'b0, 5'd10, 1'b1), 16'h1234, 0, 34, -1, -1);
        check("len_nlen",    n_len, 1);
        check("len_k",       len_k, 0);
        check("len_nvalid",  n_valid, 1);
        check("len_valid_k", valid_k, 32);
        check("len_chan",    32'(chan_idx_o), 10);
        check("len_disch",   32'(disch_o), 1);
        check("len_sample",  32'(sample_o), 32'h1234);
        check("len_other",   n_hdr + n_seq, 0);

        // en_i low mid-HDR_SHIFT: slot dropped silently, outputs hold.
        clear_mon();
        send_slot(mk_hdr(1'b1, 5'd11, 1'b1), 16'h5555, 0, 34, -1, 4);
        check("en_pulses", n_valid + n_hdr + n_len + n_seq, 0);
        check("en_chan",   32'(chan_idx_o), 10);
        check("en_imp",    32'(imp_o), 0);
        check("en_sample", 32'(sample_o), 32'h1234);
        clear_mon();
        send_slot(mk_hdr(1'b0, 5'd20, 1'b0), 16'h8001, 0, 34, -1, -1);
        check("en2_nvalid", n_valid, 1);
        check("en2_chan",   32'(chan_idx_o), 20);
        check("en2_sample", 32'(sample_o), 32'h8001);
        check("en2_nseq",   n_seq, 0);

        // Reset pulse mid-DATA_SHIFT: slot dropped, outputs cleared.
        clear_mon();
        send_slot(mk_hdr(1'b1, 5'd21, 1'b1), 16'hFFFF, 0, 34, 24, -1);
        check("rs_pulses", n_valid + n_hdr + n_len + n_seq, 0);
        check("rs_chan",   32'(chan_idx_o), 0);
        check("rs_imp",    32'(imp_o), 0);
        check("rs_disch",  32'(disch_o), 0);
        check("rs_sample", 32'(sample_o), 0);
        clear_mon();
        send_slot(mk_hdr(1'b0, 5'd3, 1'b0), 16'h0F0F, 0, 34, -1, -1);
        check("rs2_nvalid", n_valid, 1);
        check("rs2_chan",   32'(chan_idx_o), 3);
        check("rs2_sample", 32'(sample_o), 32'h0F0F);
        check("rs2_nseq",   n_seq, 0);

        check("pulse_exclusive", n_excl, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rec_rx_deframer.md
REC_RX_DEFRAMER -- requirements
Module: rec_rx_deframer

Interface
REQ-001 SHALL have parameter ADC_BITS, default 16: ADC result bits per slot, legal 1..18.
REQ-002 SHALL have parameter ADC_LAT, default 1: cycles from sample_i falling edge to first ADC bit (MSB), legal 0..(18-ADC_BITS).
REQ-003 SHALL have port clk_i  in  1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset_i  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port en_i  in  1: receiver enable; low forces IDLE.
REQ-006 SHALL have port sample_i  in  1: frame marker; high for the 16-cycle header window of each 34-cycle slot.
REQ-007 SHALL have port rec_data_i  in  1: serial lane; header bits while sample_i high, then ADC bits MSB first.
REQ-008 SHALL have port word_valid_o  out  1: one-cycle pulse, a complete slot was decoded.
REQ-009 SHALL have port chan_idx_o  out  5: channel index from header.
REQ-010 SHALL have port imp_o  out  1: impedance-mode flag from header.
REQ-011 SHALL have port disch_o  out  1: discharge flag from header.
REQ-012 SHALL have port sample_o  out  ADC_BITS: ADC result.
REQ-013 SHALL have port hdr_err_o  out  1: one-cycle pulse, no start bit within header window.
REQ-014 SHALL have port len_err_o  out  1: one-cycle pulse, slot truncated by early sample_i rise.
REQ-015 SHALL have port seq_err_o  out  1: one-cycle pulse, chan_idx not previous+1 mod 32.

Function
REQ-016 SHALL implement FSM states IDLE, HDR_WAIT, HDR_SHIFT, GAP, DATA_SHIFT.
REQ-017 IDLE->HDR_WAIT on sample_i rising edge (registered compare) with en_i high.
REQ-018 HDR_WAIT: first rec_data_i=1 while sample_i high is the start bit -> HDR_SHIFT.
REQ-019 HDR_SHIFT SHALL capture the next 7 bits MSB first as {imp, idx[4:0], disch}, then -> GAP; remaining header-window bits ignored.
REQ-020 sample_i falling while in HDR_WAIT or HDR_SHIFT SHALL pulse hdr_err_o next cycle, discard the slot, -> IDLE.
REQ-021 GAP SHALL count ADC_LAT cycles after sample_i falling edge (ADC_LAT=0: first bit sampled in the falling-edge cycle), then -> DATA_SHIFT.
REQ-022 DATA_SHIFT SHALL capture exactly ADC_BITS bits MSB first with a 5-bit down-counter.
REQ-023 Cycle after the last ADC bit: word_valid_o=1 for one cycle; chan_idx_o, imp_o, disch_o, sample_o update in that same cycle and hold until the next valid.
REQ-024 sample_i rising during GAP or DATA_SHIFT SHALL pulse len_err_o, drop partial data, go directly to HDR_WAIT (new slot not lost).
REQ-025 en_i low in any state SHALL return to IDLE next cycle with no valid/error pulse; outputs hold.
REQ-026 Expected index SHALL wrap 31->0; the first valid word after reset or en_i rise SHALL NOT flag seq_err_o.
REQ-027 At most one of word_valid_o, hdr_err_o, len_err_o SHALL assert per cycle; seq_err_o only coincides with word_valid_o.

Reset
REQ-028 reset_i high SHALL asynchronously force IDLE, all outputs 0, shift registers 0, expected-index-valid flag cleared.
REQ-029 Reset asserted mid-slot SHALL discard the slot; decoding resumes at the next sample_i rise after release.

Configuration
REQ-030 With REC_RX_SEQ_CHECK_EN defined, index continuity check and seq_err_o SHALL be implemented per REQ-015/026.
REQ-031 Without REC_RX_SEQ_CHECK_EN, seq_err_o SHALL be tied 0 and no expected-index register synthesized.

Structure
REQ-032 Package rec_rx_pkg SHALL hold the FSM state enum, SLOT_LEN=34, HDR_WIN=16, HDR_BITS=7, CHAN_NUM=32.
REQ-033 One sub-module rec_rx_shift SHALL implement the parameterized serial-in/parallel-out shift register with enable and clear, instantiated for header and data.
REQ-034 Dual-ADC lanes SHALL be handled by instantiating rec_rx_deframer twice at top level.

Verification
REQ-035 Slot with header imp=1, idx=5, disch=0, ADC=0xA5C3, ADC_LAT=1 -> one word_valid_o, chan_idx_o=5, imp_o=1, disch_o=0, sample_o=0xA5C3.
REQ-036 32 consecutive slots idx 0..31 then 0 -> 33 valids, no seq_err_o; skip idx 7 -> seq_err_o with the idx-8 word only (macro defined); never with macro undefined.
REQ-037 Header window with rec_data_i=0 for all 16 cycles -> hdr_err_o one cycle after sample_i falls, no word_valid_o.
REQ-038 sample_i rises after 6 of 16 ADC bits -> len_err_o pulse, next full slot decoded correctly.
REQ-039 reset_i pulse mid-DATA_SHIFT and en_i low mid-HDR_SHIFT -> no valid/error pulse, outputs at reset/held values, next slot decodes.
